freq_report_tx: RTL

- UART transmit side of the frequency-control link. The host writes a 5-digit ASCII decimal frequency; this block sends the active frequency back on request.
- On a request it captures a 17-bit frequency value and converts it to 5 ASCII decimal digits by sequential subtraction.
- It then serializes the digits plus CR LF as 8N1 UART frames on tx_pin.
- It sits beside the DDS core, on the same 50 MHz clock as the UART receiver.

---
 rtl/dds_pkg.sv | 41 ++++
 rtl/uart_tx_byte.sv | 61 ++++++
 rtl/freq_report_tx.sv | 125 ++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// Shared constants, types and helpers for the DDS frequency-control link.
// Used by the report transmitter and its UART byte serializer.
package dds_pkg;

   localparam logic [7:0]  ASCII_ZERO = 8'h30;
   localparam logic [7:0]  ASCII_CR   = 8'h0D;
   localparam logic [7:0]  ASCII_LF   = 8'h0A;

   localparam logic [16:0] FREQ_MAX   = 17'd99999;

   localparam logic [16:0] W_10000    = 17'd10000;
   localparam logic [16:0] W_1000     = 17'd1000;
   localparam logic [16:0] W_100      = 17'd100;
   localparam logic [16:0] W_10       = 17'd10;
   localparam logic [16:0] W_1        = 17'd1;

   localparam int NUM_DIGITS = 5;
   localparam int FRAME_BITS = 10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CONV,
      ST_SEND
   } state_t;

   function automatic logic [16:0] dec_weight(input logic [2:0] k);
      case (k)
         3'd0:    dec_weight = W_10000;
         3'd1:    dec_weight = W_1000;
         3'd2:    dec_weight = W_100;
         3'd3:    dec_weight = W_10;
         default: dec_weight = W_1;
      endcase
   endfunction

   function automatic int cycles_per_bit(input int clk_fre,
                                         input int baud_rate);
      return (clk_fre * 1000000) / baud_rate;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serializer with back-to-back accept on the
// final stop-bit cycle so consecutive frames have no idle gap.
module uart_tx_byte
   import dds_pkg::*;
#(
   parameter int CYCLES_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_pin
);

   localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES_PER_BIT - 1);
   localparam logic [3:0]    BIT_LAST = 4'(FRAME_BITS - 1);

   logic          active;
   logic [9:0]    shreg;
   logic [3:0]    bit_idx;
   logic [CW-1:0] baud_cnt;
   logic          bit_end;
   logic          frame_end;
   logic          accept;

   assign bit_end   = (baud_cnt == CNT_LAST);
   assign frame_end = active && bit_end && (bit_idx == BIT_LAST);
   assign tx_ready  = !active || frame_end;
   assign accept    = tx_valid && tx_ready;
   assign tx_pin    = active ? shreg[0] : 1'b1;

   // Load a frame on accept, otherwise shift one bit per baud period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active   <= 1'b0;
         shreg    <= '1;
         bit_idx  <= '0;
         baud_cnt <= '0;
      end else if (accept) begin
         active   <= 1'b1;
         shreg    <= {1'b1, tx_data, 1'b0};
         bit_idx  <= '0;
         baud_cnt <= '0;
      end else if (active) begin
         if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
               active <= 1'b0;
            end else begin
               bit_idx <= bit_idx + 4'd1;
               shreg   <= {1'b1, shreg[9:1]};
            end
         end else begin
            baud_cnt <= baud_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/freq_report_tx.sv
// Captures a frequency, converts it to five ASCII decimal digits by
// repeated subtraction and sends them plus CR LF over the UART.
module freq_report_tx
   import dds_pkg::*;
#(
   parameter int CLK_FRE   = 50,
   parameter int BAUD_RATE = 115200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        report_req,
   input  logic [16:0] freq_val,
   output logic        busy,
   output logic        done,
   output logic        tx_pin
);

   localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_FRE, BAUD_RATE);

   state_t      state;
   state_t      state_nxt;
   logic [16:0] rem;
   logic [2:0]  dig_k;
   logic [3:0]  digit [NUM_DIGITS];
   logic [2:0]  byte_cnt;
   logic [16:0] weight;
   logic        rem_ge;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   assign weight = dec_weight(dig_k);
   assign rem_ge = (rem >= weight);
   assign busy   = (state != ST_IDLE);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next state; first byte is offered on the last conversion cycle.
   always_comb begin
      state_nxt = state;
      tx_valid  = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (report_req) state_nxt = ST_CONV;
         end
         ST_CONV: begin
            if (!rem_ge && dig_k == 3'd4) begin
               tx_valid  = 1'b1;
               state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            if (byte_cnt != 3'd7) begin
               tx_valid = 1'b1;
            end else if (tx_ready) begin
               done      = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Byte currently offered to the serializer.
   always_comb begin
      tx_data = ASCII_LF;
      case (byte_cnt)
         3'd0:    tx_data = ASCII_ZERO + {4'd0, digit[0]};
         3'd1:    tx_data = ASCII_ZERO + {4'd0, digit[1]};
         3'd2:    tx_data = ASCII_ZERO + {4'd0, digit[2]};
         3'd3:    tx_data = ASCII_ZERO + {4'd0, digit[3]};
         3'd4:    tx_data = ASCII_ZERO + {4'd0, digit[4]};
         3'd5:    tx_data = ASCII_CR;
         default: tx_data = ASCII_LF;
      endcase
   end

   // Capture, subtract-and-count conversion, and byte sequencing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem      <= '0;
         dig_k    <= '0;
         byte_cnt <= '0;
         for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (report_req) begin
                  rem      <= (freq_val > FREQ_MAX) ? FREQ_MAX : freq_val;
                  dig_k    <= '0;
                  byte_cnt <= '0;
                  for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= '0;
               end
            end
            ST_CONV: begin
               if (rem_ge) begin
                  rem          <= rem - weight;
                  digit[dig_k] <= digit[dig_k] + 4'd1;
               end else if (dig_k != 3'd4) begin
                  dig_k <= dig_k + 3'd1;
               end
            end
            default: ;
         endcase
         if (tx_valid && tx_ready) byte_cnt <= byte_cnt + 3'd1;
      end
   end

   uart_tx_byte #(
      .CYCLES_PER_BIT (CYCLES_PER_BIT)
   ) u_uart_tx (
      .clk      (clk),
      .rst      (rst),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_pin   (tx_pin)
   );

endmodule
